// File: rtl/mem_bus_loader.sv
// rtl/mem_bus_loader.sv - byte-framed bus initiator
// Parses W/R frames from a byte source, runs one bus access, returns ack or read data.
module mem_bus_loader #(
  parameter int BUS_TIMEOUT   = 256,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int BW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int FW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);
  localparam logic [FW-1:0] GAP_LAST = FW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t r_state, w_next;

  logic          r_is_wr;
  logic          r_tmo;
  logic [1:0]    r_bcnt;
  logic [1:0]    r_ridx;
  logic [31:2]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [BW-1:0] r_bus_cnt;
  logic [FW-1:0] r_gap_cnt;

  logic w_cmd_ok;
  logic w_rx_fire;
  logic w_tx_fire;
  logic w_bus_exp;
  logic w_gap_exp;
  logic w_resp_last;

  assign w_cmd_ok    = (rx_data == 8'h57) || (rx_data == 8'h52);
  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_tx_fire   = tx_valid && tx_ready;
  assign w_bus_exp   = (r_bus_cnt == BUS_LAST);
  assign w_gap_exp   = (r_gap_cnt == GAP_LAST);
  assign w_resp_last = r_tmo || r_is_wr || (r_ridx == 2'd3);

  assign mem_addr  = {r_addr, 2'b00};
  assign mem_wdata = r_wdata;
  assign mem_wstrb = (r_state == S_BUS && r_is_wr) ? 4'hF : 4'h0;

  always_comb begin
    tx_data = 8'h00;
    if (r_state == S_RESP) begin
      if (r_tmo)        tx_data = 8'hEE;
      else if (r_is_wr) tx_data = 8'h4B;
      else begin
        case (r_ridx)
          2'd0:    tx_data = r_rdata[7:0];
          2'd1:    tx_data = r_rdata[15:8];
          2'd2:    tx_data = r_rdata[23:16];
          default: tx_data = r_rdata[31:24];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rx_ready  = 1'b0;
    mem_valid = 1'b0;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
        if (rx_valid && w_cmd_ok) w_next = S_ADDR;
      end
      S_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (r_bcnt == 2'd3) w_next = r_is_wr ? S_DATA : S_BUS;
        end else if (w_gap_exp) begin
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (r_bcnt == 2'd3) w_next = S_BUS;
        end else if (w_gap_exp) begin
          w_next = S_IDLE;
        end
      end
      S_BUS: begin
        mem_valid = 1'b1;
        if (mem_ready || w_bus_exp) w_next = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        if (tx_ready && w_resp_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr   <= 1'b0;
      r_tmo     <= 1'b0;
      r_bcnt    <= 2'd0;
      r_ridx    <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bus_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire && w_cmd_ok) begin
            r_is_wr   <= (rx_data == 8'h57);
            r_tmo     <= 1'b0;
            r_bcnt    <= 2'd0;
            r_ridx    <= 2'd0;
            r_gap_cnt <= '0;
          end
        end
        S_ADDR, S_DATA: begin
          r_bus_cnt <= '0;
          if (w_rx_fire) begin
            r_bcnt    <= r_bcnt + 2'd1;
            r_gap_cnt <= '0;
            if (r_state == S_DATA) begin
              r_wdata <= {rx_data, r_wdata[31:8]};
            end else begin
              // Low two address bits are never stored: the bus is word-addressed.
              case (r_bcnt)
                2'd0:    r_addr[7:2]   <= rx_data[7:2];
                2'd1:    r_addr[15:8]  <= rx_data;
                2'd2:    r_addr[23:16] <= rx_data;
                default: r_addr[31:24] <= rx_data;
              endcase
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + FW'(1);
          end
        end
        S_BUS: begin
          if (mem_ready)      r_rdata   <= mem_rdata;
          else if (w_bus_exp) r_tmo     <= 1'b1;
          else                r_bus_cnt <= r_bus_cnt + BW'(1);
        end
        S_RESP: begin
          if (w_tx_fire) r_ridx <= r_ridx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_loader.sv
// tb/tb_mem_bus_loader.sv - randomized bench for mem_bus_loader
// Expected bus accesses and reply bytes are derived from the frame contents alone.
module tb_mem_bus_loader;

  localparam int BT = 16;
  localparam int FT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_loader #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) check_eq("rx_accept", 0, 1);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat, input int stall,
                        input bit offer_rx, input int gap);
    logic [7:0] exp_q[$];
    bit   timed_out, stable, stall_ok;
    int   cnt, exp_cycles;
    logic [31:0] first_addr;

    timed_out  = (lat >= BT);
    exp_cycles = timed_out ? BT : lat + 1;
    exp_q = {};
    if (timed_out)  exp_q.push_back(8'hEE);
    else if (wr)    exp_q.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));

    send_byte(wr ? 8'h57 : 8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) & 32'hFF), gap);
    if (wr) for (int i = 0; i < 4; i++) send_byte(8'((wdata >> (8 * i)) & 32'hFF), gap);

    @(negedge clk);
    check_eq("bus_entry_valid", {31'd0, mem_valid}, 1);
    check_eq("bus_addr", mem_addr, {addr[31:2], 2'b00});
    check_eq("bus_wstrb", {28'd0, mem_wstrb}, wr ? 32'hF : 32'h0);
    if (wr) check_eq("bus_wdata", mem_wdata, wdata);
    first_addr = mem_addr;
    stable = 1'b1;
    cnt = 0;
    for (int g = 0; g < BT + 4; g++) begin
      if (g > 0) @(negedge clk);
      if (!mem_valid) break;
      cnt++;
      if (mem_addr !== first_addr || rx_ready !== 1'b0 || tx_valid !== 1'b0) stable = 1'b0;
      if (cnt == lat + 1) begin mem_ready = 1'b1; mem_rdata = rdata; end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      tx_ready  = (stall == 0);
      rx_valid  = offer_rx && (stall > 0);
      rx_data   = 8'h52;
    end
    check_eq("bus_valid_cycles", cnt, exp_cycles);
    check_eq("bus_stable", {31'd0, stable}, 1);
    check_eq("resp_first_valid", {31'd0, tx_valid}, 1);

    stall_ok = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int k = 0; k < stall; k++) begin
        if (tx_valid !== 1'b1 || tx_data !== exp_q[i] || rx_ready !== 1'b0) stall_ok = 1'b0;
        @(posedge clk); #1;
        if (k == stall - 1) begin
          tx_ready = 1'b1;
          if (i == exp_q.size() - 1) rx_valid = 1'b0;
        end
        @(negedge clk);
      end
      check_eq("tx_valid", {31'd0, tx_valid}, 1);
      check_eq("tx_byte", {24'd0, tx_data}, {24'd0, exp_q[i]});
      @(posedge clk); #1;
      tx_ready = (stall == 0) && (i != exp_q.size() - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    if (stall > 0) check_eq("tx_stall_hold", {31'd0, stall_ok}, 1);
    check_eq("done_busy", {31'd0, busy}, 0);
    check_eq("done_tx_valid", {31'd0, tx_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit bad;
    logic [7:0] junk;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 1);
    check_eq("rst_mem_valid", {31'd0, mem_valid}, 0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_outs", mem_addr | mem_wdata | {28'd0, mem_wstrb} | {24'd0, tx_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0010_0013, 32'h0, 32'h1234_5678, 1, 0, 1'b0, 0);
    do_txn(1'b0, 32'hA5A5_0004, 32'h0, 32'h0BAD_F00D, BT, 0, 1'b0, 0);
    do_txn(1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0, 0, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0000_0044, 32'h0, 32'h8765_4321, BT - 1, 0, 1'b0, 0);

    send_byte(8'h00, 0);
    @(negedge clk);
    check_eq("bad_cmd_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    send_byte(8'h57, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bad = 1'b0;
    for (int i = 1; i <= FT; i++) begin
      @(negedge clk);
      if (mem_valid || tx_valid) bad = 1'b1;
      if (i == FT) check_eq("gap_last_busy", {31'd0, busy}, 1);
    end
    @(negedge clk);
    check_eq("gap_no_access", {31'd0, bad}, 0);
    check_eq("gap_idle", {31'd0, busy}, 0);
    @(posedge clk); #1;
    do_txn(1'b0, 32'h0000_0100, 32'h0, 32'h5566_7788, 2, 0, 1'b0, 0);

    do_txn(1'b0, 32'h0000_0200, 32'h0, 32'hFEDC_BA98, 2, 10, 1'b1, 0);
    do_txn(1'b1, 32'h0001_0300, 32'h1357_9BDF, 32'h0, 1, 0, 1'b0, FT - 1);

    mem_ready = 1'b1;
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (busy || tx_valid) bad = 1'b1; end
    mem_ready = 1'b0;
    check_eq("idle_ready_ignored", {31'd0, bad}, 0);
    @(posedge clk); #1;

    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h40, 0);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_valid", {31'd0, mem_valid}, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_mem_valid", {31'd0, mem_valid}, 0);
    check_eq("arst_tx_valid", {31'd0, tx_valid}, 0);
    check_eq("arst_busy", {31'd0, busy}, 0);
    check_eq("arst_rx_ready", {31'd0, rx_ready}, 1);
    #2 rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin @(negedge clk); if (mem_valid || tx_valid || busy) bad = 1'b1; end
    check_eq("post_rst_quiet", {31'd0, bad}, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
        send_byte(junk, 0);
        @(negedge clk);
        check_eq("rand_bad_cmd", {31'd0, busy}, 0);
        @(posedge clk); #1;
      end
      do_txn(1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, BT + 2)), int'($urandom_range(0, 2)),
             1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
